key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 Parameter: HOLD_CYCLES, default 24'd50_000_000, cycles a key must be held before the first repeat event.
REQ-002 Parameter: REPEAT_CYCLES, default 24'd10_000_000, cycles between later repeat events.
REQ-003 Parameter: DEPTH, default 8, event FIFO entries; a power of 2, minimum 2.
REQ-004 Port: clk  input  1  system clock; every register updates on its rising edge.
REQ-005 Port: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 Port: key_ready  input  1  debounced "exactly one key down" flag from the keypad scanner.
REQ-007 Port: key_code  input  5  scanner keycode; {col[2:0], row[1:0]}; meaningful only while key_ready=1.
REQ-008 Port: evt_valid  output  1  FIFO non-empty; head event is presented.
REQ-009 Port: evt_ready  input  1  consumer pop strobe; a pop occurs on an edge where evt_valid & evt_ready.
REQ-010 Port: evt_code  output  5  keycode of the head event.
REQ-011 Port: evt_type  output  2  head event type: 01 press, 10 release, 11 repeat; 00 never stored.
REQ-012 Port: held  output  1  high while the FSM is in PRESSED or REPEAT.
REQ-013 Port: held_code  output  5  latched code of the held key; holds its last value when held=0.
REQ-014 Port: overflow  output  1  sticky flag; set when an event is dropped because the FIFO is full.
REQ-015 Port: clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-016 FSM states: IDLE, PRESSED, REPEAT; the FSM generates at most one event per edge.
REQ-017 IDLE, key_ready=1 sampled: push {key_code, press}, latch held_code=key_code, clear the timer, go to PRESSED.
REQ-018 PRESSED/REPEAT, key_ready=0: push {held_code, release}, go to IDLE.
REQ-019 PRESSED/REPEAT, key_ready=1 with key_code != held_code: push {held_code, release}, go to IDLE; the new key's press is pushed on the next edge under REQ-017.
REQ-020 PRESSED, same key, timer == HOLD_CYCLES-1: push {held_code, repeat}, clear the timer, go to REPEAT; otherwise increment the timer.
REQ-021 REPEAT, same key, timer == REPEAT_CYCLES-1: push {held_code, repeat}, clear the timer; otherwise increment the timer.
REQ-022 Timing: press at edge E0 gives the first repeat at E0+HOLD_CYCLES and later repeats every REPEAT_CYCLES edges.
REQ-023 If release/change and timer expiry coincide, the release wins and no repeat is pushed.
REQ-024 Timer: 24-bit, never wraps; it is cleared on every state entry.
REQ-025 FIFO is circular, with pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits; pointers wrap from DEPTH-1 to 0.
REQ-026 Outputs evt_valid, evt_code and evt_type are driven from registered FIFO state only; an event pushed at edge N is visible after edge N.
REQ-027 Push when count==DEPTH with no pop on the same edge: the event is dropped, FIFO contents are unchanged and overflow is set.
REQ-028 Push and pop on the same edge: both take effect, count is unchanged, including when count==DEPTH (no drop) or count==0 is impossible since a pop needs evt_valid.
REQ-029 evt_ready while evt_valid=0: ignored; no pointer moves.
REQ-030 clr_overflow and a new drop on the same edge: overflow stays 1 (set wins).
REQ-031 The FSM never stalls on a full FIFO; key tracking continues and events are dropped.

Reset
REQ-032 While rst_n=0: state IDLE, timer 0, pointers 0, count 0, evt_valid 0, evt_code 0, evt_type 00, held 0, held_code 0, overflow 0.
REQ-033 Reset mid-operation discards all queued events and any held-key context; after deassertion, a still-pressed key produces a fresh press event at the first edge that samples key_ready=1.
REQ-034 Deassertion is used synchronised to clk by the integrating top level; this block assumes no extra synchroniser.

Verification (HOLD_CYCLES=8, REPEAT_CYCLES=4, DEPTH=4, evt_ready=1 unless stated)
REQ-035 Tap: key_ready=1, code 5'h06 for 3 cycles, then 0 -> exactly press(06) followed by release(06); held high for 3 cycles.
REQ-036 Hold: code 5'h11 held for 20 cycles from press edge E0 -> repeats at E0+8, E0+12, E0+16, E0+20 only if still held at that edge, then release.
REQ-037 Key change: 5'h02 held, then switches to 5'h0B without a gap -> release(02) on the change edge, press(0B) on the next edge.
REQ-038 Overflow: evt_ready=0 and 3 taps (6 events) -> first 4 events retained in order, overflow=1; clr_overflow pulse -> overflow=0; drain returns those 4 events.
REQ-039 Full plus simultaneous pop: count=4, evt_ready=1 on the edge of a push -> no drop, overflow stays 0, count stays 4.
REQ-040 Reset mid-hold: assert rst_n=0 in REPEAT with 2 queued events -> all outputs at reset values; after release of reset with the key still down -> single press event.

Source files
------------

// File: rtl/key_event_ctrl.sv
// -----------------------------------------------------------------------------
// key_event_ctrl
//
// Turns the keypad scanner's "exactly one key down" flag into a stream of
// press / release / auto-repeat events. Events are queued in a small circular
// FIFO so a slow consumer (firmware polling loop, UART bridge) does not miss
// them. When the FIFO is full, new events are dropped and a sticky overflow
// flag is raised. Key tracking never stalls on a full FIFO.
//
// Event stream handshake:
//   evt_valid is high whenever the FIFO holds at least one event, and
//   evt_code/evt_type then describe the oldest one. A pop happens on every
//   rising edge where evt_valid && evt_ready. evt_ready while evt_valid=0 is
//   ignored. evt_valid/evt_code/evt_type never depend combinationally on
//   evt_ready or on the key inputs, so an event pushed at edge N first
//   appears just after edge N.
//
// Parameters:
//   HOLD_CYCLES   - edges from the press edge to the first repeat event
//   REPEAT_CYCLES - edges between later repeat events
//   DEPTH         - FIFO entries; must be a power of 2 and at least 2
//
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset (deassertion already
//                  synchronised by the integrating top level)
//   key_ready    - debounced "exactly one key down" flag
//   key_code     - {col[2:0], row[1:0]}, meaningful only while key_ready=1
//   evt_valid    - head event is presented (FIFO non-empty)
//   evt_ready    - consumer pop strobe
//   evt_code     - keycode of the head event
//   evt_type     - 01 press, 10 release, 11 repeat (00 is never stored)
//   held         - a key is currently being tracked (PRESSED or REPEAT)
//   held_code    - code of the tracked key; keeps its last value when idle
//   overflow     - sticky: an event was dropped because the FIFO was full
//   clr_overflow - synchronous clear of overflow (a same-edge drop wins)
//   fsm_state    - debug view of the tracker state:
//                  00 IDLE, 01 PRESSED, 10 REPEAT
// -----------------------------------------------------------------------------
module key_event_ctrl #(
    parameter logic [23:0] HOLD_CYCLES   = 24'd50_000_000,
    parameter logic [23:0] REPEAT_CYCLES = 24'd10_000_000,
    parameter int          DEPTH         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_ready,
    input  logic [4:0] key_code,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [4:0] evt_code,
    output logic [1:0] evt_type,
    output logic       held,
    output logic [4:0] held_code,
    output logic       overflow,
    input  logic       clr_overflow,
    output logic [1:0] fsm_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    // Timer values at which the repeat fires; the timer counts edges spent
    // in the current state, starting from 0 right after entry.
    localparam logic [23:0] HOLD_LAST   = HOLD_CYCLES - 24'd1;
    localparam logic [23:0] REPEAT_LAST = REPEAT_CYCLES - 24'd1;
    localparam logic [23:0] TIMER_MAX   = 24'hFF_FFFF;

    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01,
        ST_REPEAT  = 2'b10
    } state_t;

    state_t      state;
    logic [23:0] timer;

    // -------------------------------------------------------------------------
    // Event decision. At most one of do_press/do_release/do_repeat is set on
    // any edge. Release has priority over a coinciding timer expiry, and a
    // code change counts as a release of the held key; the new key's press
    // follows one edge later from IDLE.
    // -------------------------------------------------------------------------
    logic       same_key;
    logic       do_press;
    logic       do_release;
    logic       do_repeat;
    logic       push_en;
    logic [6:0] push_word;
    logic [23:0] timer_inc;

    assign same_key  = key_ready && (key_code == held_code);
    // Saturating increment: the timer never wraps back to a value that
    // could fire a spurious repeat.
    assign timer_inc = (timer != TIMER_MAX) ? (timer + 24'd1) : timer;

    always_comb begin
        do_press   = 1'b0;
        do_release = 1'b0;
        do_repeat  = 1'b0;
        case (state)
            ST_IDLE: begin
                do_press = key_ready;
            end
            ST_PRESSED: begin
                if (!same_key) begin
                    do_release = 1'b1;
                end else if (timer == HOLD_LAST) begin
                    do_repeat = 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!same_key) begin
                    do_release = 1'b1;
                end else if (timer == REPEAT_LAST) begin
                    do_repeat = 1'b1;
                end
            end
            default: begin
                do_press = 1'b0;
            end
        endcase
    end

    always_comb begin
        push_en   = do_press | do_release | do_repeat;
        push_word = {held_code, EVT_REPEAT};
        if (do_press) begin
            push_word = {key_code, EVT_PRESS};
        end else if (do_release) begin
            push_word = {held_code, EVT_RELEASE};
        end
    end

    // -------------------------------------------------------------------------
    // Key tracker FSM. Timer is cleared on every state entry (including the
    // REPEAT -> REPEAT re-arm after each repeat event).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            timer     <= 24'd0;
            held      <= 1'b0;
            held_code <= 5'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (do_press) begin
                        state     <= ST_PRESSED;
                        held      <= 1'b1;
                        held_code <= key_code;
                        timer     <= 24'd0;
                    end
                end
                ST_PRESSED: begin
                    if (do_release) begin
                        state <= ST_IDLE;
                        held  <= 1'b0;
                        timer <= 24'd0;
                    end else if (do_repeat) begin
                        state <= ST_REPEAT;
                        timer <= 24'd0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_REPEAT: begin
                    if (do_release) begin
                        state <= ST_IDLE;
                        held  <= 1'b0;
                        timer <= 24'd0;
                    end else if (do_repeat) begin
                        timer <= 24'd0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    held  <= 1'b0;
                    timer <= 24'd0;
                end
            endcase
        end
    end

    assign fsm_state = state;

    // -------------------------------------------------------------------------
    // Event FIFO. Pointers are log2(DEPTH) bits and wrap naturally because
    // DEPTH is a power of 2. A push into a full FIFO still succeeds when a pop
    // happens on the same edge, since the pop frees the slot.
    // -------------------------------------------------------------------------
    logic [6:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    assign fifo_full = (count == FULL_COUNT);
    assign do_pop    = evt_valid & evt_ready;
    assign do_push   = push_en & (~fifo_full | do_pop);
    assign drop      = push_en & fifo_full & ~do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only ever read after being written,
    // and the head outputs are forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    logic [6:0] head_word;

    assign head_word = mem[rd_ptr];
    assign evt_valid = (count != '0);
    assign evt_code  = evt_valid ? head_word[6:2] : 5'd0;
    assign evt_type  = evt_valid ? head_word[1:0] : 2'b00;

endmodule

// File: tb/tb_key_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_event_ctrl
//
// Bench for key_event_ctrl with HOLD_CYCLES=8, REPEAT_CYCLES=4, DEPTH=4.
// A reference model tracks the held key by the edge index of its press and
// decides repeats arithmetically; the FIFO is modelled as a queue of
// {code, type} words. A vector table covers tap, key change and overflow;
// hand sequences cover long holds, release/expiry coincidence, full+pop,
// clear/drop collision and reset mid-hold; a random phase follows.
// -----------------------------------------------------------------------------
module tb_key_event_ctrl;

  localparam int HOLD  = 8;
  localparam int REP   = 4;
  localparam int DEPTH = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic       key_ready;
  logic [4:0] key_code;
  logic       evt_valid;
  logic       evt_ready;
  logic [4:0] evt_code;
  logic [1:0] evt_type;
  logic       held;
  logic [4:0] held_code;
  logic       overflow;
  logic       clr_overflow;
  logic [1:0] fsm_state;

  key_event_ctrl #(
    .HOLD_CYCLES  (24'd8),
    .REPEAT_CYCLES(24'd4),
    .DEPTH        (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_type    (evt_type),
    .held        (held),
    .held_code   (held_code),
    .overflow    (overflow),
    .clr_overflow(clr_overflow),
    .fsm_state   (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  logic [6:0] exp_q[$];   // {code, type}, head at index 0
  int         cyc = 0;    // edges since bench start (outside reset)
  int         m_start;    // edge index of the current press
  bit         m_held;
  logic [4:0] m_code;
  logic       m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_held = 0;
    m_code = 5'd0;
    m_ovf  = 1'b0;
  endtask

  // One rising edge of the reference: decide the event from the held-key
  // context, then apply pop-before-push to the queue.
  task automatic model_edge(input logic kr, input logic [4:0] kc, input logic er,
                            input logic clr);
    bit         gen;
    bit         pop;
    bit         drop;
    logic [6:0] ev;
    int         k;
    gen  = 0;
    drop = 0;
    ev   = 7'd0;
    pop  = (exp_q.size() > 0) && er;
    if (!m_held) begin
      if (kr) begin
        gen     = 1;
        ev      = {kc, 2'b01};
        m_held  = 1;
        m_code  = kc;
        m_start = cyc;
      end
    end else if (!kr || kc != m_code) begin
      gen    = 1;
      ev     = {m_code, 2'b10};
      m_held = 0;
    end else begin
      k = cyc - m_start;
      if (k == HOLD || (k > HOLD && ((k - HOLD) % REP) == 0)) begin
        gen = 1;
        ev  = {m_code, 2'b11};
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (gen) begin
      if (exp_q.size() == DEPTH) drop = 1;
      else exp_q.push_back(ev);
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    cyc++;
  endtask

  task automatic compare_model(input string tag);
    logic [6:0] head;
    chk({tag, " evt_valid"}, evt_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk({tag, " evt_code"}, evt_code, head[6:2]);
      chk({tag, " evt_type"}, evt_type, head[1:0]);
    end
    chk({tag, " held"}, held, m_held);
    chk({tag, " held_code"}, held_code, m_code);
    chk({tag, " overflow"}, overflow, m_ovf);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " evt_valid"}, evt_valid, 0);
    chk({tag, " evt_code"}, evt_code, 0);
    chk({tag, " evt_type"}, evt_type, 0);
    chk({tag, " held"}, held, 0);
    chk({tag, " held_code"}, held_code, 0);
    chk({tag, " overflow"}, overflow, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: called at a falling edge; drives inputs, lets one rising edge
  // pass, advances the model and compares at the next falling edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic kr, input logic [4:0] kc, input logic er,
                      input logic clr, input string tag);
    key_ready    = kr;
    key_code     = kc;
    evt_ready    = er;
    clr_overflow = clr;
    @(posedge clk);
    model_edge(kr, kc, er, clr);
    @(negedge clk);
    compare_model(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       kr;
    logic [4:0] kc;
    logic       er;
    logic       clr;
    logic       x_valid;
    logic [4:0] x_code;
    logic [1:0] x_type;
    logic       x_held;
    logic [4:0] x_hcode;
    logic       x_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic kr, logic [4:0] kc, logic er, logic clr,
                              logic xv, logic [4:0] xc, logic [1:0] xt,
                              logic xh, logic [4:0] xhc, logic xo);
    vec_t v;
    v.kr = kr; v.kc = kc; v.er = er; v.clr = clr;
    v.x_valid = xv; v.x_code = xc; v.x_type = xt;
    v.x_held = xh; v.x_hcode = xhc; v.x_ovf = xo;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  int rep_seen;

  initial begin
    key_ready    = 1'b0;
    key_code     = 5'd0;
    evt_ready    = 1'b1;
    clr_overflow = 1'b0;
    rst_n        = 1'b0;
    model_reset();

    // Tap: 06 for three edges then released.
    tbl.push_back(mk(1, 5'h06, 1, 0, 1, 5'h06, 2'b01, 1, 5'h06, 0));
    tbl.push_back(mk(1, 5'h06, 1, 0, 0, 5'h00, 2'b00, 1, 5'h06, 0));
    tbl.push_back(mk(1, 5'h06, 1, 0, 0, 5'h00, 2'b00, 1, 5'h06, 0));
    tbl.push_back(mk(0, 5'h00, 1, 0, 1, 5'h06, 2'b10, 0, 5'h06, 0));
    tbl.push_back(mk(0, 5'h00, 1, 0, 0, 5'h00, 2'b00, 0, 5'h06, 0));
    // Key change 02 -> 0B without a gap.
    tbl.push_back(mk(1, 5'h02, 1, 0, 1, 5'h02, 2'b01, 1, 5'h02, 0));
    tbl.push_back(mk(1, 5'h02, 1, 0, 0, 5'h00, 2'b00, 1, 5'h02, 0));
    tbl.push_back(mk(1, 5'h0B, 1, 0, 1, 5'h02, 2'b10, 0, 5'h02, 0));
    tbl.push_back(mk(1, 5'h0B, 1, 0, 1, 5'h0B, 2'b01, 1, 5'h0B, 0));
    tbl.push_back(mk(0, 5'h00, 1, 0, 1, 5'h0B, 2'b10, 0, 5'h0B, 0));
    tbl.push_back(mk(0, 5'h00, 1, 0, 0, 5'h00, 2'b00, 0, 5'h0B, 0));
    // Overflow: three taps with no consumer, then clear and drain.
    tbl.push_back(mk(1, 5'h01, 0, 0, 1, 5'h01, 2'b01, 1, 5'h01, 0));
    tbl.push_back(mk(0, 5'h00, 0, 0, 1, 5'h01, 2'b01, 0, 5'h01, 0));
    tbl.push_back(mk(1, 5'h02, 0, 0, 1, 5'h01, 2'b01, 1, 5'h02, 0));
    tbl.push_back(mk(0, 5'h00, 0, 0, 1, 5'h01, 2'b01, 0, 5'h02, 0));
    tbl.push_back(mk(1, 5'h03, 0, 0, 1, 5'h01, 2'b01, 1, 5'h03, 1));
    tbl.push_back(mk(0, 5'h00, 0, 0, 1, 5'h01, 2'b01, 0, 5'h03, 1));
    tbl.push_back(mk(0, 5'h00, 0, 1, 1, 5'h01, 2'b01, 0, 5'h03, 0));
    tbl.push_back(mk(0, 5'h00, 1, 0, 1, 5'h01, 2'b10, 0, 5'h03, 0));
    tbl.push_back(mk(0, 5'h00, 1, 0, 1, 5'h02, 2'b01, 0, 5'h03, 0));
    tbl.push_back(mk(0, 5'h00, 1, 0, 1, 5'h02, 2'b10, 0, 5'h03, 0));
    tbl.push_back(mk(0, 5'h00, 1, 0, 0, 5'h00, 2'b00, 0, 5'h03, 0));

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // Table phase.
    foreach (tbl[i]) begin
      string t;
      t = $sformatf("tbl%0d", i);
      step(tbl[i].kr, tbl[i].kc, tbl[i].er, tbl[i].clr, t);
      chk({t, " x_valid"}, evt_valid, tbl[i].x_valid);
      if (tbl[i].x_valid) begin
        chk({t, " x_code"}, evt_code, tbl[i].x_code);
        chk({t, " x_type"}, evt_type, tbl[i].x_type);
      end
      chk({t, " x_held"}, held, tbl[i].x_held);
      chk({t, " x_hcode"}, held_code, tbl[i].x_hcode);
      chk({t, " x_ovf"}, overflow, tbl[i].x_ovf);
    end

    // Long hold of 11: press edge plus 20 more edges, then release.
    rep_seen = 0;
    for (int n = 0; n <= 20; n++) begin
      step(1, 5'h11, 1, 0, "hold");
      if (evt_valid && evt_type == 2'b11) rep_seen++;
    end
    chk("hold repeat_count", rep_seen, 4);
    step(0, 5'h00, 1, 0, "hold_rel");
    chk("hold release_type", evt_type, 2'b10);
    step(0, 5'h00, 1, 0, "hold_idle");

    // Release on the edge where the first repeat would fire.
    for (int n = 0; n < HOLD; n++) step(1, 5'h15, 1, 0, "coin");
    step(0, 5'h00, 1, 0, "coin_rel");
    chk("coin release_wins", evt_type, 2'b10);
    step(0, 5'h00, 1, 0, "coin_idle");

    // Full FIFO with a pop on the push edge, then drop/clear collisions.
    step(1, 5'h1A, 0, 0, "full");
    step(0, 5'h00, 0, 0, "full");
    step(1, 5'h1B, 0, 0, "full");
    step(0, 5'h00, 0, 0, "full");
    step(1, 5'h1C, 1, 0, "full_pop_push");
    chk("full_pop_push overflow", overflow, 0);
    step(1, 5'h1C, 0, 0, "full_hold");
    step(0, 5'h00, 0, 0, "full_drop");
    chk("full_drop overflow", overflow, 1);
    step(0, 5'h00, 0, 1, "clr");
    step(1, 5'h1D, 0, 1, "clr_vs_drop");
    chk("clr_vs_drop overflow", overflow, 1);
    for (int n = 0; n < 6; n++) step(0, 5'h00, 1, 0, "drain");

    // Reset mid-hold with two queued events (press + first repeat).
    for (int n = 0; n < 10; n++) step(1, 5'h11, 0, 0, "prereset");
    chk("prereset queued", exp_q.size() == 2 && evt_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset("rst_async");
    model_reset();
    @(negedge clk);
    check_reset("rst_hold");
    rst_n = 1'b1;
    step(1, 5'h11, 0, 0, "post_reset_press");
    chk("post_reset type", evt_type, 2'b01);
    step(1, 5'h11, 1, 0, "post_reset_single");
    chk("post_reset single", evt_valid, 0);
    step(0, 5'h00, 1, 0, "post_reset_rel");
    step(0, 5'h00, 1, 0, "post_reset_idle");

    // Randomised phase against the model.
    begin
      logic       kr;
      logic [4:0] kc;
      logic       er;
      logic       clr;
      int         r;
      kr = 1'b0;
      kc = 5'd0;
      for (int n = 0; n < 500; n++) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          kr = ~kr;
          kc = 5'($urandom_range(0, 31));
        end else if (r == 1 && kr) begin
          kc = 5'($urandom_range(0, 31));
        end
        er  = ((n % 100) < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
        clr = ($urandom_range(0, 19) == 0);
        step(kr, kr ? kc : 5'd0, er, clr, "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
